// File: rtl/div_check_if.sv
// Valid/ready handshake bundle for div_check_sequencer.
// Word side:   in_valid, in_ready, in_data (WIDTH bits).
// Result side: out_valid, out_ready, out_residue (RES_W bits), out_divisible.
// The master modport is the producer/consumer side. The slave modport is the sequencer.
interface div_check_if #(
   parameter int unsigned WIDTH   = 8,
   parameter int unsigned DIVISOR = 5
);
   localparam int unsigned RES_W = $clog2(DIVISOR);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             out_valid;
   logic             out_ready;
   logic [RES_W-1:0] out_residue;
   logic             out_divisible;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_residue, out_divisible
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_residue, out_divisible
   );
endinterface

// File: rtl/div_check_sequencer.sv
// Bit-serial mod-DIVISOR residue sequencer.
// Takes a WIDTH-bit word over valid/ready and walks it MSB-first through the
// residue recurrence. It returns the residue and a divisible flag over
// valid/ready, and keeps a saturating count of divisible words it has delivered.
// Ports: clk, rst_n (async, active-low), flush (sync abort),
//        bus (div_check_if.slave: word in / result out), busy, div_count.
module div_check_sequencer #(
   parameter int unsigned WIDTH   = 8,
   parameter int unsigned DIVISOR = 5,
   parameter int unsigned CNT_W   = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   div_check_if.slave       bus,
   output logic             busy,
   output logic [CNT_W-1:0] div_count
);
   localparam int unsigned RES_W  = $clog2(DIVISOR);
   localparam int unsigned BCNT_W = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t            state;
   logic [WIDTH-1:0]  shreg;
   logic [BCNT_W-1:0] bit_cnt;
   logic [RES_W-1:0]  residue;

   logic [RES_W:0]    t_c;
   logic [RES_W-1:0]  res_nxt_c;

   // One step of the recurrence: append the next MSB, then reduce once.
   // The residue stays below DIVISOR, so a single conditional subtract is enough.
   always_comb begin
      t_c       = {residue, shreg[WIDTH-1]};
      res_nxt_c = t_c[RES_W-1:0];
      if (t_c >= (RES_W+1)'(DIVISOR)) begin
         res_nxt_c = RES_W'(t_c - (RES_W+1)'(DIVISOR));
      end
   end

   // Sequencer FSM. All outputs are registered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state             <= IDLE;
         shreg             <= '0;
         bit_cnt           <= '0;
         residue           <= '0;
         bus.in_ready      <= 1'b1;
         bus.out_valid     <= 1'b0;
         bus.out_residue   <= '0;
         bus.out_divisible <= 1'b0;
         busy              <= 1'b0;
         div_count         <= '0;
      end else if (flush) begin
         // Abort. Any pending result is dropped and the count is left alone.
         state         <= IDLE;
         residue       <= '0;
         bus.in_ready  <= 1'b1;
         bus.out_valid <= 1'b0;
         busy          <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  shreg        <= bus.in_data;
                  residue      <= '0;
                  bit_cnt      <= BCNT_W'(WIDTH);
                  state        <= SHIFT;
                  bus.in_ready <= 1'b0;
                  busy         <= 1'b1;
               end
            end
            SHIFT: begin
               residue <= res_nxt_c;
               shreg   <= shreg << 1;
               bit_cnt <= bit_cnt - BCNT_W'(1);
               if (bit_cnt == BCNT_W'(1)) begin
                  state             <= DONE;
                  bus.out_valid     <= 1'b1;
                  bus.out_residue   <= res_nxt_c;
                  bus.out_divisible <= (res_nxt_c == '0);
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  state         <= IDLE;
                  bus.out_valid <= 1'b0;
                  bus.in_ready  <= 1'b1;
                  busy          <= 1'b0;
                  if (bus.out_divisible && (div_count != {CNT_W{1'b1}})) begin
                     div_count <= div_count + CNT_W'(1);
                  end
               end
            end
            default: begin
               state         <= IDLE;
               bus.out_valid <= 1'b0;
               bus.in_ready  <= 1'b1;
               busy          <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_div_check_sequencer.sv
// Scoreboard bench for div_check_sequencer.
// The stimulus pushes the expected {divisible, residue} of each word into a queue.
// The monitor pops one entry on each result handshake and compares it.
module tb_div_check_sequencer;
   localparam int unsigned WIDTH   = 8;
   localparam int unsigned DIVISOR = 5;
   localparam int unsigned CNT_W   = 16;
   localparam int unsigned RES_W   = $clog2(DIVISOR);

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             flush = 1'b0;
   logic             busy;
   logic [CNT_W-1:0] div_count;

   div_check_if #(.WIDTH(WIDTH), .DIVISOR(DIVISOR)) bus ();

   div_check_sequencer #(.WIDTH(WIDTH), .DIVISOR(DIVISOR), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .bus       (bus),
      .busy      (busy),
      .div_count (div_count)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_fail = 0;
   int model_cnt = 0;
   bit rand_rdy = 1'b0;
   logic [RES_W:0] exp_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
      end
   endtask

   // Result monitor. It samples on the falling edge, ahead of the handshake edge.
   always @(negedge clk) begin
      logic [RES_W:0] e;
      if (rst_n && !flush && bus.out_valid && bus.out_ready) begin
         if (exp_q.size() == 0) begin
            check("unexpected_result", 32'(1), 32'(0));
         end else begin
            e = exp_q.pop_front();
            check("result", 32'({bus.out_divisible, bus.out_residue}), 32'(e));
            if (e[RES_W]) model_cnt++;
         end
      end
   end

   // Random consumer back-pressure.
   always @(posedge clk) begin
      if (rand_rdy) begin
         #1 bus.out_ready = 1'($urandom_range(0, 1));
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   task automatic send(input logic [WIDTH-1:0] w, input logic [RES_W:0] e);
      int n = 0;
      while (!bus.in_ready && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      check("in_ready_wait", 32'(bus.in_ready), 32'(1));
      exp_q.push_back(e);
      bus.in_valid = 1'b1;
      bus.in_data  = w;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((busy || bus.out_valid) && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      check("idle_wait", 32'(busy), 32'(0));
   endtask

   initial begin
      int lat;
      logic seen;
      logic [WIDTH-1:0] v;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b1;

      // Reset state.
      #12;
      check("rst_out_valid", 32'(bus.out_valid), 32'(0));
      check("rst_busy", 32'(busy), 32'(0));
      check("rst_div_count", 32'(div_count), 32'(0));
      check("rst_residue", 32'({bus.out_divisible, bus.out_residue}), 32'(0));
      @(posedge clk); #1 rst_n = 1'b1;
      #1 check("rst_in_ready", 32'(bus.in_ready), 32'(1));

      // 1: 10 -> residue 0, divisible. The result appears 8 edges after accept.
      send(8'h0A, {1'b1, 3'd0});
      lat = 0;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk); #1;
         if (bus.out_valid) begin
            lat = i;
            break;
         end
      end
      check("latency", 32'(lat), 32'(8));
      wait_idle();
      check("cnt_after_10", 32'(div_count), 32'(1));

      // 2: 181 -> residue 1.
      send(8'hB5, {1'b0, 3'd1});
      wait_idle();
      check("cnt_after_181", 32'(div_count), 32'(1));

      // 3: 255 with back-pressure. The result must hold steady.
      bus.out_ready = 1'b0;
      send(8'hFF, {1'b1, 3'd0});
      for (int i = 0; i < 30 && !bus.out_valid; i++) begin
         @(posedge clk); #1;
      end
      for (int i = 0; i < 5; i++) begin
         check("hold", 32'({bus.out_valid, bus.out_divisible, bus.out_residue, bus.in_ready, busy}),
               32'({1'b1, 1'b1, 3'd0, 1'b0, 1'b1}));
         @(posedge clk); #1;
      end
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      check("release_idle", 32'({busy, bus.in_ready, bus.out_valid}), 32'({1'b0, 1'b1, 1'b0}));
      check("cnt_after_255", 32'(div_count), 32'(2));

      // 4: flush on the third SHIFT edge drops the word.
      send(8'h05, {1'b1, 3'd0});
      @(posedge clk); #1;
      @(posedge clk); #1;
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      void'(exp_q.pop_back());
      check("flush_idle", 32'({busy, bus.in_ready, bus.out_valid}), 32'({1'b0, 1'b1, 1'b0}));
      seen = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         if (bus.out_valid) seen = 1'b1;
      end
      check("flush_no_result", 32'(seen), 32'(0));
      check("cnt_after_flush", 32'(div_count), 32'(2));
      send(8'h0F, {1'b1, 3'd0});
      wait_idle();
      check("cnt_after_15", 32'(div_count), 32'(3));

      // 5: asynchronous reset in the middle of SHIFT.
      send(8'hFF, {1'b1, 3'd0});
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      check("midrst_outs", 32'({bus.out_valid, busy, bus.out_divisible, bus.out_residue}), 32'(0));
      check("midrst_cnt", 32'(div_count), 32'(0));
      exp_q.delete();
      model_cnt = 0;
      @(posedge clk); #1 rst_n = 1'b1;

      // 6: random words with random back-pressure.
      rand_rdy = 1'b1;
      for (int k = 0; k < 200; k++) begin
         v = WIDTH'($urandom_range(0, 255));
         send(v, {(v % 5) == 0, 3'(v % 5)});
      end
      rand_rdy = 1'b0;
      @(posedge clk); #2;
      bus.out_ready = 1'b1;
      wait_idle();
      @(negedge clk); #1;
      check("queue_drained", 32'(exp_q.size()), 32'(0));
      check("cnt_random", 32'(div_count), 32'(model_cnt));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
